tensor_operand_dispatch: RTL and testbench

- Parametrised successor to the single-stream read-to-write loop-back inside the tensor-core top.
- Takes the AXI-read beat stream (A, B, C tiles arriving back-to-back in one stream) and demultiplexes it into NUM_CH independent operand channels.
- Each channel has its own first-word-fall-through FIFO, so the systolic array can consume A, B and C at different rates.
- Per-job beat counts per channel are latched at start; a done pulse marks the job's last routed beat.

---
 rtl/tensor_operand_dispatch.sv | 150 +++++++++++++++
 tb/tb_tensor_operand_dispatch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_operand_dispatch.sv
// rtl/tensor_operand_dispatch.sv - demultiplexes one read-beat stream into NUM_CH operand FIFOs by per-channel counts
// Beats are routed strictly by count: channel order is ascending, zero-count channels are skipped.
module tensor_operand_dispatch #(
  parameter int DATA_W     = 256,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [NUM_CH*CNT_W-1:0]                     ch_cnt,
  input  logic [DATA_W-1:0]                           s_dat,
  input  logic                                        s_valid,
  output logic                                        s_ready,
  output logic [NUM_CH*DATA_W-1:0]                    m_dat,
  output logic [NUM_CH-1:0]                           m_valid,
  input  logic [NUM_CH-1:0]                           m_ready,
  output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]    ch_level,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        start_err
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ROUTE, DONE} state_t;

  state_t            state;
  logic [CH_W-1:0]   cur;
  logic [CNT_W-1:0]  rem [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic              cur_full;
  logic [CNT_W-1:0]  cur_rem;
  logic              first_found;
  logic [CH_W-1:0]   first_ch;
  logic              nxt_found;
  logic [CH_W-1:0]   nxt_ch;
  logic              xfer;

  // Channel selection: current channel's status, first non-empty count at start,
  // and the next higher channel with beats left for the advance after the last beat.
  always_comb begin
    cur_full    = 1'b0;
    cur_rem     = '0;
    first_found = 1'b0;
    first_ch    = '0;
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (CH_W'(j) == cur) begin
        cur_full = full[j];
        cur_rem  = rem[j];
      end
      if (!first_found && ch_cnt[j*CNT_W +: CNT_W] != '0) begin
        first_found = 1'b1;
        first_ch    = CH_W'(j);
      end
      if (!nxt_found && CH_W'(j) > cur && rem[j] != '0) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(j);
      end
    end
  end

  assign s_ready = (state == ROUTE) && !cur_full;
  assign xfer    = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      for (int j = 0; j < NUM_CH; j++) rem[j] <= '0;
    end else begin
      done      <= 1'b0;
      start_err <= start && (state != IDLE);
      for (int j = 0; j < NUM_CH; j++) begin
        if (xfer && CH_W'(j) == cur) rem[j] <= rem[j] - CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < NUM_CH; j++) rem[j] <= ch_cnt[j*CNT_W +: CNT_W];
            if (first_found) begin
              cur   <= first_ch;
              state <= ROUTE;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ROUTE: begin
          if (xfer && cur_rem == CNT_W'(1)) begin
            if (nxt_found) begin
              cur <= nxt_ch;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              do_push;
    logic              do_pop;

    // s_ready already excludes a full FIFO, so a routed transfer is always a legal push.
    assign full[g]  = (level == LVL_W'(FIFO_DEPTH));
    assign do_push  = xfer && (cur == CH_W'(g));
    assign do_pop   = (level != '0) && m_ready[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
      end
    end

    always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= s_dat;
    end

    assign m_dat[g*DATA_W +: DATA_W]   = mem[rd_ptr];
    assign m_valid[g]                  = (level != '0);
    assign ch_level[g*LVL_W +: LVL_W]  = level;
  end

endmodule

// File: tb/tb_tensor_operand_dispatch.sv
// tb/tb_tensor_operand_dispatch.sv - scoreboard bench for tensor_operand_dispatch
module tb_tensor_operand_dispatch;

  localparam int DW    = 32;
  localparam int NCH   = 5;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [NCH*CW-1:0] ch_cnt = '0;
  logic [DW-1:0]     s_dat = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [NCH*DW-1:0] m_dat;
  logic [NCH-1:0]    m_valid;
  logic [NCH-1:0]    m_ready = '0;
  logic [NCH*LW-1:0] ch_level;
  logic              busy;
  logic              done;
  logic              start_err;

  tensor_operand_dispatch #(
    .DATA_W(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_cnt(ch_cnt),
    .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .m_dat(m_dat), .m_valid(m_valid), .m_ready(m_ready),
    .ch_level(ch_level), .busy(busy), .done(done), .start_err(start_err)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  logic [DW-1:0]  exp_q [NCH][$];
  logic [DW-1:0]  exp_beat;
  int             done_cnt = 0;
  int             err_cnt = 0;
  logic [NCH-1:0] valid_seen = '0;
  int             job_cnt [NCH];
  int             alt_cnt [NCH];

  // Output side of the scoreboard: every pop is compared with the oldest expected beat.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (start_err) err_cnt++;
    valid_seen |= m_valid;
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (ch_level[i*LW +: LW] > LW'(DEPTH) || m_valid[i] !== (ch_level[i*LW +: LW] != '0)) begin
        errors++;
        $display("FAIL level_ch%0d: level=%0d valid=%b, required level<=%0d and valid==(level!=0)",
                 i, ch_level[i*LW +: LW], m_valid[i], DEPTH);
      end
      if (m_valid[i] && m_ready[i]) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat_ch%0d: got %h, required no beat", i, m_dat[i*DW +: DW]);
        end else begin
          exp_beat = exp_q[i].pop_front();
          if (m_dat[i*DW +: DW] !== exp_beat) begin
            errors++;
            $display("FAIL beat_order_ch%0d: got %h, required %h", i, m_dat[i*DW +: DW], exp_beat);
          end
        end
      end
    end
  end

  task automatic pack_cnt(input bit use_alt);
    for (int i = 0; i < NCH; i++)
      ch_cnt[i*CW +: CW] = use_alt ? CW'(alt_cnt[i]) : CW'(job_cnt[i]);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NCH; i++) exp_q[i].delete();
  endtask

  task automatic drain_and_check(input int d0);
    int cyc;
    int pending;
    m_ready = '1;
    cyc = 0;
    pending = 1;
    while (pending != 0 && cyc < 100) begin
      @(negedge clk);
      pending = 0;
      for (int i = 0; i < NCH; i++) pending += exp_q[i].size();
      cyc++;
    end
    checks++;
    if (pending != 0) begin
      errors++;
      $display("FAIL drain: %0d beats still expected, required 0", pending);
    end
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL done_count: got %0d, required 1", done_cnt - d0);
    end
  endtask

  // Input side: the expected split is built from job_cnt and beats are queued as they are accepted.
  task automatic run_job(input logic [DW-1:0] base, input int vpct, input int rpct, input int restart_at);
    int chq[$];
    int total, k, cyc, d0, e0;
    for (int c = 0; c < NCH; c++)
      for (int n = 0; n < job_cnt[c]; n++) chq.push_back(c);
    total = chq.size();
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge clk); #1;
    pack_cnt(1'b0);
    start = 1'b1;
    k = 0;
    cyc = 0;
    while (k < total && cyc < 4000) begin
      @(posedge clk); #1;
      start = (cyc == restart_at);
      if (start) pack_cnt(1'b1);
      s_valid = (int'($urandom_range(99)) < vpct);
      s_dat = base + DW'(k) + 1;
      for (int i = 0; i < NCH; i++) m_ready[i] = (int'($urandom_range(99)) < rpct);
      @(negedge clk);
      if (restart_at >= 0 && cyc == restart_at + 1) begin
        checks++;
        if (start_err !== 1'b1) begin
          errors++;
          $display("FAIL start_err_pulse: got %b, required 1", start_err);
        end
      end
      if (s_valid && s_ready) begin
        exp_q[chq[k]].push_back(s_dat);
        k++;
      end
      cyc++;
    end
    checks++;
    if (k < total) begin
      errors++;
      $display("FAIL route_timeout: routed %0d, required %0d", k, total);
    end
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_timing: done=%b s_ready=%b, required done=1 s_ready=0", done, s_ready);
    end
    drain_and_check(d0);
    if (restart_at >= 0) begin
      checks++;
      if (err_cnt != e0 + 1) begin
        errors++;
        $display("FAIL start_err_count: got %0d, required 1", err_cnt - e0);
      end
    end
    m_ready = '0;
  endtask

  task automatic set_job(input int c0, input int c1, input int c2, input int c3, input int c4);
    job_cnt[0] = c0; job_cnt[1] = c1; job_cnt[2] = c2; job_cnt[3] = c3; job_cnt[4] = c4;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, busy, done, start_err, m_valid} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: s_ready=%b busy=%b done=%b start_err=%b m_valid=%b, required all 0",
               s_ready, busy, done, start_err, m_valid);
    end
    checks++;
    if (ch_level !== '0) begin
      errors++;
      $display("FAIL reset_level: got %h, required 0", ch_level);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_job(2, 3, 1, 0, 0);
    run_job(32'h0, 100, 100, -1);
  endtask

  task automatic test_zero_skip();
    set_job(0, 0, 2, 0, 0);
    valid_seen = '0;
    run_job(32'h9, 100, 100, -1);
    checks++;
    if (valid_seen[1:0] !== 2'b00 || valid_seen[4:3] !== 2'b00) begin
      errors++;
      $display("FAIL zero_skip_valid: seen=%b, required only bit 2", valid_seen);
    end
    set_job(0, 0, 0, 0, 0);
    run_job(32'h0, 100, 100, -1);
  endtask

  task automatic test_backpressure();
    int k, cyc, d0;
    set_job(12, 0, 0, 0, 0);
    d0 = done_cnt;
    @(posedge clk); #1;
    pack_cnt(1'b0);
    start = 1'b1;
    m_ready = '0;
    s_valid = 1'b1;
    k = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      s_dat = DW'(k) + 1;
      @(negedge clk);
      if (s_valid && s_ready) begin
        exp_q[0].push_back(s_dat);
        k++;
      end
    end
    checks++;
    if (k != 8 || s_ready !== 1'b0 || ch_level[LW-1:0] !== LW'(8) || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_stall: beats=%0d s_ready=%b level=%0d busy=%b, required 8 0 8 1",
               k, s_ready, ch_level[LW-1:0], busy);
    end
    m_ready[0] = 1'b1;
    cyc = 0;
    while (k < 12 && cyc < 50) begin
      @(posedge clk); #1;
      s_dat = DW'(k) + 1;
      @(negedge clk);
      if (s_valid && s_ready) begin
        exp_q[0].push_back(s_dat);
        k++;
      end
      cyc++;
    end
    checks++;
    if (k != 12) begin
      errors++;
      $display("FAIL backpressure_resume: routed %0d, required 12", k);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_done: got %b, required 1", done);
    end
    drain_and_check(d0);
    m_ready = '0;
  endtask

  task automatic test_start_busy();
    set_job(4, 4, 4, 0, 0);
    for (int i = 0; i < NCH; i++) alt_cnt[i] = 1;
    run_job(32'h200, 100, 100, 3);
  endtask

  task automatic test_async_reset();
    int k, cyc;
    set_job(4, 4, 4, 0, 0);
    @(posedge clk); #1;
    pack_cnt(1'b0);
    start = 1'b1;
    m_ready = '0;
    s_valid = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 20) begin
      @(posedge clk); #1;
      start = 1'b0;
      s_dat = 32'h100 + DW'(k);
      @(negedge clk);
      if (s_valid && s_ready) begin
        exp_q[k / 4].push_back(s_dat);
        k++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, busy, done, start_err, m_valid} !== '0) begin
      errors++;
      $display("FAIL async_reset_ctrl: s_ready=%b busy=%b done=%b start_err=%b m_valid=%b, required all 0",
               s_ready, busy, done, start_err, m_valid);
    end
    checks++;
    if (ch_level !== '0) begin
      errors++;
      $display("FAIL async_reset_level: got %h, required 0", ch_level);
    end
    clear_queues();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_job(0, 0, 1, 0, 0);
    run_job(32'h300, 100, 100, -1);
  endtask

  task automatic test_soak();
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < NCH; i++) job_cnt[i] = int'($urandom_range(40));
      run_job(DW'(j + 1) << 16, 70, 60, -1);
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      job_cnt[i] = 0;
      alt_cnt[i] = 0;
    end
    test_reset();
    test_basic();
    test_zero_skip();
    test_backpressure();
    test_start_busy();
    test_async_reset();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
